// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner
//   Avalon-MM slave driving a multiplexed ROWS x COLS LED matrix, one row lit
//   at a time. The CPU writes row patterns into a shadow buffer; a swap
//   requested through CTRL copies the whole shadow buffer into the active
//   buffer on a frame boundary, so a displayed frame never tears.
//
//   Optional feature macro: LED_MATRIX_PWM_EN
//     defined   : CTRL[7:4] BRIGHT is R/W and limits the lit part of each dwell
//                 to (BRIGHT+1)/16 of it.
//     undefined : CTRL[7:4] reads 0, writes are ignored, full dwell is lit.
//
// Ports
//   clk, reset_n     system clock, asynchronous active-low reset
//   address          Avalon word address
//                      0..ROWS-1 shadow rows, ROWS CTRL, ROWS+1 STATUS
//   chipselect       slave select
//   write_n          active-low write strobe
//   writedata        write data
//   readdata         read data, combinational (zero wait states)
//   row_sel          one-hot row drive, registered
//   col_out          column data of the selected row, registered
//   frame_irq        level interrupt, FRAME_DONE & IRQ_EN
module led_matrix_scanner #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DWELL  = 1024,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_out,
  output logic              frame_irq
);

  localparam int RW    = $clog2(ROWS);
  localparam int DW    = $clog2(DWELL);
  localparam int SLICE = DWELL / 16;

  // The FSM state doubles as the CTRL.EN bit.
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            blank_q;
  logic            irq_en_q;
`ifdef LED_MATRIX_PWM_EN
  logic [3:0]      bright_q;
`endif
  logic [COLS-1:0] shadow_q [ROWS];
  logic [COLS-1:0] active_q [ROWS];
  logic [RW-1:0]   row_idx_q;
  logic [DW-1:0]   dwell_cnt_q;
  logic [7:0]      frame_cnt_q;
  logic            swap_pending_q;
  logic            frame_done_q;
  logic [ROWS-1:0] row_sel_q;
  logic [COLS-1:0] col_out_q;

  logic wr_en, wr_shadow, wr_ctrl, wr_stat;
  logic scan_run, dwell_end, row_end, frame_end, lit;
  logic unused_wd;

  assign wr_en     = chipselect & ~write_n;
  assign wr_shadow = wr_en && (address <  ADDR_W'(ROWS));
  assign wr_ctrl   = wr_en && (address == ADDR_W'(ROWS));
  assign wr_stat   = wr_en && (address == ADDR_W'(ROWS + 1));

  // Bits of writedata beyond the register widths are intentionally ignored.
  assign unused_wd = ^writedata;

  assign state_d = wr_ctrl ? (writedata[0] ? SCAN : IDLE) : state_q;

  // Scanning only while EN stays set across this edge, so clearing EN drops
  // to IDLE on the write edge and setting EN starts from row 0 / dwell 0.
  assign scan_run  = (state_q == SCAN) && (state_d == SCAN);
  assign dwell_end = (dwell_cnt_q == DW'(DWELL - 1));
  assign row_end   = (row_idx_q == RW'(ROWS - 1));
  assign frame_end = scan_run && dwell_end && row_end;

  // dwell_cnt == 0 is a dark gap at every row change to suppress ghosting.
  always_comb begin
    lit = !blank_q && (dwell_cnt_q != '0);
`ifdef LED_MATRIX_PWM_EN
    lit = lit && (((32'(bright_q) + 32'd1) * 32'(SLICE)) > 32'(dwell_cnt_q));
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      blank_q        <= 1'b0;
      irq_en_q       <= 1'b0;
`ifdef LED_MATRIX_PWM_EN
      bright_q       <= 4'd0;
`endif
      for (int i = 0; i < ROWS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      row_idx_q      <= '0;
      dwell_cnt_q    <= '0;
      frame_cnt_q    <= 8'd0;
      swap_pending_q <= 1'b0;
      frame_done_q   <= 1'b0;
      row_sel_q      <= '0;
      col_out_q      <= '0;
    end else begin
      state_q <= state_d;
      if (wr_ctrl) begin
        blank_q  <= writedata[1];
        irq_en_q <= writedata[3];
`ifdef LED_MATRIX_PWM_EN
        bright_q <= writedata[7:4];
`endif
      end
      if (wr_shadow)
        shadow_q[address[RW-1:0]] <= writedata[COLS-1:0];

      if (scan_run) begin
        if (dwell_end) begin
          dwell_cnt_q <= '0;
          row_idx_q   <= row_end ? '0 : row_idx_q + RW'(1);
        end else begin
          dwell_cnt_q <= dwell_cnt_q + DW'(1);
        end
      end else begin
        dwell_cnt_q <= '0;
        row_idx_q   <= '0;
      end

      // Swap reads shadow_q before this edge's write, so a same-edge shadow
      // write lands only in the shadow buffer.
      if (frame_end) begin
        frame_cnt_q <= frame_cnt_q + 8'd1;
        if (swap_pending_q)
          for (int i = 0; i < ROWS; i++) active_q[i] <= shadow_q[i];
      end

      // A SWAP request on the boundary edge is kept for the next boundary.
      if (wr_ctrl && writedata[2])
        swap_pending_q <= 1'b1;
      else if (frame_end)
        swap_pending_q <= 1'b0;

      // Frame completion beats a simultaneous write-1-to-clear.
      if (frame_end)
        frame_done_q <= 1'b1;
      else if (wr_stat && writedata[0])
        frame_done_q <= 1'b0;

      row_sel_q <= scan_run ? (ROWS'(1) << row_idx_q) : '0;
      col_out_q <= (scan_run && lit) ? active_q[row_idx_q] : '0;
    end
  end

  always_comb begin
    readdata = 32'd0;
    if (address < ADDR_W'(ROWS)) begin
      readdata[COLS-1:0] = shadow_q[address[RW-1:0]];
    end else if (address == ADDR_W'(ROWS)) begin
      readdata[0] = (state_q == SCAN);
      readdata[1] = blank_q;
      readdata[3] = irq_en_q;
`ifdef LED_MATRIX_PWM_EN
      readdata[7:4] = bright_q;
`endif
    end else if (address == ADDR_W'(ROWS + 1)) begin
      readdata[0]    = frame_done_q;
      readdata[1]    = swap_pending_q;
      readdata[7:4]  = 4'(row_idx_q);
      readdata[15:8] = frame_cnt_q;
    end
  end

  assign row_sel   = row_sel_q;
  assign col_out   = col_out_q;
  assign frame_irq = frame_done_q & irq_en_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
module tb_led_matrix_scanner;
  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int DWELL  = 16;
  localparam int ADDR_W = 5;
  localparam int CTRL   = ROWS;
  localparam int STAT   = ROWS + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [ROWS-1:0]   row_sel;
  logic [COLS-1:0]   col_out;
  logic              frame_irq;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  led_matrix_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .row_sel(row_sel), .col_out(col_out), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; the write is taken on the following posedge.
  task automatic wr(input int a, input logic [31:0] d);
    address    = ADDR_W'(a);
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    cyc++;
  endtask

  task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
    address = ADDR_W'(a);
    #1;
    chk(tag, readdata, exp);
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    for (int a = 0; a < 32; a++) rd_chk($sformatf("rst_rd%0d", a), a, 32'd0);
    chk("rst_row_sel", 32'(row_sel), 32'd0);
    chk("rst_col_out", 32'(col_out), 32'd0);
    chk("rst_irq", 32'(frame_irq), 32'd0);

    // Load walking-one pattern, then enable with a swap request
    for (int r = 0; r < ROWS; r++) wr(r, 32'(1 << r));
    rd_chk("shadow5", 5, 32'h20);
    wr(CTRL, 32'h05);
    cyc = 0;
    rd_chk("ctrl_swap_reads0", CTRL, 32'h01);
    wait_to(3);
    chk("f1_row_sel", 32'(row_sel), 32'h01);
    chk("f1_col_dark", 32'(col_out), 32'h00);
    wait_to(127);
    rd_chk("stat_pre_boundary", STAT, 32'h72);
    wait_to(128);
    rd_chk("stat_frame1", STAT, 32'h101);
    chk("irq_masked", 32'(frame_irq), 32'd0);

    // Second frame shows the swapped pattern, dark on dwell 0
    for (int r = 0; r < ROWS; r++) begin
      wait_to(128 + 16 * r + 1);
      chk($sformatf("f2_gap_col%0d", r), 32'(col_out), 32'h00);
      chk($sformatf("f2_gap_row%0d", r), 32'(row_sel), 32'(1 << r));
      wait_to(128 + 16 * r + 2);
      chk($sformatf("f2_col%0d", r), 32'(col_out), 32'(1 << r));
      chk($sformatf("f2_row%0d", r), 32'(row_sel), 32'(1 << r));
    end

    // Interrupt enable and write-1-to-clear
    wr(CTRL, 32'h09);
    chk("irq_on", 32'(frame_irq), 32'd1);
    wr(STAT, 32'h01);
    chk("irq_cleared", 32'(frame_irq), 32'd0);
    wait_to(255);
    chk("irq_before_f2", 32'(frame_irq), 32'd0);
    wait_to(256);
    chk("irq_f2", 32'(frame_irq), 32'd1);
    rd_chk("stat_frame2", STAT, 32'h201);
    wr(STAT, 32'h01);
    rd_chk("stat_cleared", STAT, 32'h200);

    // Clear on the boundary edge: set wins
    wait_to(383);
    wr(STAT, 32'h01);
    rd_chk("stat_set_wins", STAT, 32'h301);

    // Shadow write without swap leaves the display alone
    wr(3, 32'hFF);
    wait_to(434);
    chk("row3_unchanged", 32'(col_out), 32'h08);
    wr(CTRL, 32'h0D);
    wait_to(511);
    rd_chk("stat_pending", STAT, 32'h373);
    wait_to(512);
    rd_chk("stat_swapped", STAT, 32'h401);
    wait_to(562);
    chk("row3_new_col", 32'(col_out), 32'hFF);
    chk("row3_new_sel", 32'(row_sel), 32'h08);

    // Asynchronous reset mid row 5
    wait_to(597);
    chk("row5_before_rst", 32'(row_sel), 32'h20);
    reset_n = 1'b0;
    #1;
    chk("arst_row_sel", 32'(row_sel), 32'd0);
    chk("arst_col_out", 32'(col_out), 32'd0);
    chk("arst_irq", 32'(frame_irq), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("arst_ctrl", CTRL, 32'd0);
    rd_chk("arst_stat", STAT, 32'd0);
    rd_chk("arst_shadow3", 3, 32'd0);
    wr(CTRL, 32'h01);
    cyc = 0;
    wait_to(50);
    chk("arst_active_row", 32'(row_sel), 32'h08);
    chk("arst_active_col", 32'(col_out), 32'h00);

    // EN 1->0 drops the outputs on the write edge
    wr(CTRL, 32'h00);
    chk("idle_row_sel", 32'(row_sel), 32'd0);
    rd_chk("idle_stat", STAT, 32'd0);

    // Brightness field
    wr(0, 32'hAA);
    wr(CTRL, 32'h35);
    cyc = 0;
`ifdef LED_MATRIX_PWM_EN
    rd_chk("ctrl_bright_rd", CTRL, 32'h31);
`else
    rd_chk("ctrl_bright_rd", CTRL, 32'h01);
`endif
    wait_to(132);
    chk("dwell3_col", 32'(col_out), 32'hAA);
    wait_to(133);
`ifdef LED_MATRIX_PWM_EN
    chk("dwell4_col", 32'(col_out), 32'h00);
`else
    chk("dwell4_col", 32'(col_out), 32'hAA);
`endif
    wait_to(144);
`ifdef LED_MATRIX_PWM_EN
    chk("dwell15_col", 32'(col_out), 32'h00);
`else
    chk("dwell15_col", 32'(col_out), 32'hAA);
`endif

    // Blanking keeps rows scanning with dark columns
    wr(CTRL, 32'h03);
    wait_to(150);
    chk("blank_row_sel", 32'(row_sel), 32'h02);
    chk("blank_col", 32'(col_out), 32'h00);

    // Unmapped address ignores writes and reads zero
    wr(20, 32'hFFFF_FFFF);
    rd_chk("unmapped_rd", 20, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
